hash_score_tracker: RTL and testbench
=====================================

Name: hash_score_tracker

Overview:
- Consumes the 64-bit XOR words the ALU produces when its output select is XOR, one word per cycle.
- Each word is hash word XOR target word. Each candidate hash spans WORDS_PER_HASH words.
- Per candidate: population count of every word, accumulation into a Hamming-distance score, comparison against the running best.
- Records the lowest score and its nonce for the host readout.

Parameters:
- WORDS_PER_HASH, 16: XOR words per candidate (1024-bit Skein state / 64).
- NONCE_W, 64: width of the candidate identifier.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous reset, active low
- word_valid_i  input  1  word_i holds a valid ALU XOR word this cycle
- word_i  input  64  ALU XOR output word
- word_last_i  input  1  final word of the candidate; qualified by word_valid_i
- nonce_i  input  NONCE_W  candidate id; sampled on the first valid word of a candidate
- clear_best_i  input  1  discard best record and sticky error
- score_valid_o  output  1  one-cycle pulse; score_o and score_nonce_o are valid
- score_o  output  SCORE_W  Hamming distance of the just-finished candidate
- score_nonce_o  output  NONCE_W  nonce of the just-finished candidate
- new_best_o  output  1  one-cycle pulse, coincident with score_valid_o, when best was replaced
- best_valid_o  output  1  a best record exists
- best_score_o  output  SCORE_W  lowest score since reset/clear
- best_nonce_o  output  NONCE_W  nonce of best_score_o
- frame_error_o  output  1  sticky malformed-candidate flag

Behaviour:
- Reset (rst_ni low, asynchronous), all outputs reset as follows:
  - score_valid_o, new_best_o, best_valid_o, frame_error_o: 0
  - score_o, score_nonce_o, best_nonce_o: 0
  - best_score_o: all ones
  - Pipeline valids, accumulator and word counter: 0; next word is treated as first of a candidate.
- No backpressure: a word is accepted every cycle word_valid_i is high. Bubbles are allowed mid-candidate and hold all state.
- Stage 1, registered on an accepted word:
  - pc_q <= popcount(word_i), 7 bits.
  - Also registers valid, last and first flags.
  - When first, nonce_q <= nonce_i.
- Stage 2, on stage-1 valid:
  - sum = (first ? 0 : acc_q) + pc_q, SCORE_W bits. This cannot overflow: maximum 64*WORDS_PER_HASH.
  - word_cnt advances, saturating not needed.
  - If not last: acc_q <= sum.
- Completion: on the stage-2 cycle where last is set and word_cnt == WORDS_PER_HASH-1:
  - score_o <= sum, score_nonce_o <= nonce_q, score_valid_o <= 1.
  - If !best_valid_o or sum < best_score_o: best_score_o <= sum, best_nonce_o <= nonce_q, best_valid_o <= 1, new_best_o <= 1.
  - Ties keep the earlier nonce.
- Latency: word_last_i accepted at edge N -> score_valid_o, new_best_o and updated best_* visible after edge N+2.
- Frame errors:
  - Triggers: last with word_cnt != WORDS_PER_HASH-1, or a WORDS_PER_HASH-th word without last.
  - Response: frame_error_o <= 1 (sticky), no score pulse, candidate dropped, next accepted word starts a new candidate.
- clear_best_i, registered at the edge it is sampled:
  - best_valid_o <= 0, best_score_o <= all ones, best_nonce_o <= 0, frame_error_o <= 0. The in-flight accumulation is unaffected.
  - If a completion lands on the same edge, clear applies first and the completing candidate becomes the best (best_valid_o = 1, new_best_o = 1).
- Reset mid-candidate: partial accumulation is discarded; no score pulse follows.

Decomposition:
- Shared package skein_pkg holds:
  - SCORE_W = $clog2(64*WORDS_PER_HASH+1), which is 11 at the default.
  - SCORE_MAX = all ones of SCORE_W.
  - POPCNT_W = 7.
- Sub-module popcount64: combinational 64-bit population count, 7-bit output, adder-tree. It is reusable by the ALU bit counter.

Test Plan:
- After reset, 16 words of 64'h0 with last on word 16, nonce 5 -> score_valid_o 2 cycles after last, score_o 0, new_best_o 1, best_score_o 0, best_nonce_o 5.
- Candidate A: 16 words 64'hFFFF_FFFF_FFFF_FFFF, nonce 1 -> score 1024, best 1024/1. Candidate B: 16 words 64'h1, nonce 2 -> score 16, new_best_o 1, best 16/2. Candidate C: same score 16, nonce 3 -> new_best_o 0, best_nonce_o stays 2.
- Random bubbles (word_valid_i low 0-3 cycles) inside a 16-word candidate with popcounts 1..16 -> score_o 136, same as without bubbles.
- last asserted on word 10 -> frame_error_o 1, no score_valid_o. Next well-formed candidate still scores correctly.
- Back-to-back candidates with no gap (word 1 of next right after last) -> two score pulses 16 cycles apart, accumulator restarts at 0.
- clear_best_i on the same edge as a completion scoring 500 while best is 100 -> best_score_o 500, best_valid_o 1, new_best_o 1, frame_error_o 0.
- rst_ni pulsed low after word 8 -> outputs at reset values immediately; a following complete candidate scores correctly.

Source files
------------

// File: rtl/skein_pkg.sv
// Shared widths for the Skein hash-scoring datapath.
// Score widths derive from the number of 64-bit words in one 1024-bit state.
package skein_pkg;

    localparam int HASH_WORDS = 16;
    localparam int POPCNT_W   = 7;
    localparam int SCORE_W    = $clog2(64 * HASH_WORDS + 1);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    // A candidate replaces the best only when strictly lower, so ties keep the earlier nonce.
    function automatic logic beats_best(input logic [SCORE_W-1:0] score,
                                        input logic [SCORE_W-1:0] best,
                                        input logic               best_vld);
        return !best_vld || (score < best);
    endfunction

endpackage

// File: rtl/popcount64.sv
// Combinational 64-bit population count built as a balanced adder tree.
// Zero latency; no flow control.
module popcount64
    import skein_pkg::*;
(
    input  logic [63:0]         data_i,
    output logic [POPCNT_W-1:0] count_o
);

    logic [1:0] lvl1 [32];
    logic [2:0] lvl2 [16];
    logic [3:0] lvl3 [8];
    logic [4:0] lvl4 [4];
    logic [5:0] lvl5 [2];

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            lvl1[i] = {1'b0, data_i[2*i]} + {1'b0, data_i[2*i+1]};
        end
        for (int i = 0; i < 16; i++) begin
            lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
        end
        for (int i = 0; i < 8; i++) begin
            lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            lvl4[i] = {1'b0, lvl3[2*i]} + {1'b0, lvl3[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            lvl5[i] = {1'b0, lvl4[2*i]} + {1'b0, lvl4[2*i+1]};
        end
        count_o = {1'b0, lvl5[0]} + {1'b0, lvl5[1]};
    end

endmodule

// File: rtl/hash_score_tracker.sv
// Scores each candidate hash by the Hamming distance of its XOR words and keeps the best one.
// Latency: last word accepted at edge N -> score/best visible after edge N+2; never stalls input.
module hash_score_tracker
    import skein_pkg::*;
#(
    parameter int WORDS_PER_HASH = HASH_WORDS,
    parameter int NONCE_W        = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               word_valid_i,
    input  logic [63:0]        word_i,
    input  logic               word_last_i,
    input  logic [NONCE_W-1:0] nonce_i,
    input  logic               clear_best_i,
    output logic               score_valid_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [NONCE_W-1:0] score_nonce_o,
    output logic               new_best_o,
    output logic               best_valid_o,
    output logic [SCORE_W-1:0] best_score_o,
    output logic [NONCE_W-1:0] best_nonce_o,
    output logic               frame_error_o
);

    localparam int CNT_W = (WORDS_PER_HASH > 1) ? $clog2(WORDS_PER_HASH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_HASH - 1);

    logic [POPCNT_W-1:0] pc;

    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic                s1_vld_q, s1_vld_d;
    logic                s1_last_q, s1_last_d;
    logic                s1_first_q, s1_first_d;
    logic [CNT_W-1:0]    s1_idx_q, s1_idx_d;
    logic [POPCNT_W-1:0] pc_q, pc_d;
    logic [NONCE_W-1:0]  nonce_q, nonce_d;

    logic [SCORE_W-1:0]  sum;
    logic                is_end;
    logic [SCORE_W-1:0]  acc_q, acc_d;
    logic                s2_done_q, s2_done_d;
    logic                s2_err_q, s2_err_d;
    logic [SCORE_W-1:0]  s2_sum_q, s2_sum_d;
    logic [NONCE_W-1:0]  s2_nonce_q, s2_nonce_d;

    logic                score_valid_q, score_valid_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [NONCE_W-1:0]  score_nonce_q, score_nonce_d;
    logic                new_best_q, new_best_d;
    logic                best_valid_q, best_valid_d;
    logic [SCORE_W-1:0]  best_score_q, best_score_d;
    logic [NONCE_W-1:0]  best_nonce_q, best_nonce_d;
    logic                frame_error_q, frame_error_d;

    popcount64 u_popcount (
        .data_i  (word_i),
        .count_o (pc)
    );

    // Word position is tracked at the input so the first-word flag and nonce capture
    // are already correct for a word arriving right behind a dropped candidate.
    always_comb begin
        word_cnt_d = word_cnt_q;
        s1_vld_d   = word_valid_i;
        s1_last_d  = s1_last_q;
        s1_first_d = s1_first_q;
        s1_idx_d   = s1_idx_q;
        pc_d       = pc_q;
        nonce_d    = nonce_q;
        if (word_valid_i) begin
            word_cnt_d = (word_last_i || (word_cnt_q == LAST_IDX)) ? '0 : word_cnt_q + 1'b1;
            s1_last_d  = word_last_i;
            s1_first_d = (word_cnt_q == '0);
            s1_idx_d   = word_cnt_q;
            pc_d       = pc;
            if (word_cnt_q == '0) begin
                nonce_d = nonce_i;
            end
        end
    end

    always_comb begin
        sum        = (s1_first_q ? '0 : acc_q) + SCORE_W'(pc_q);
        is_end     = (s1_idx_q == LAST_IDX);
        acc_d      = acc_q;
        s2_done_d  = s1_vld_q && s1_last_q && is_end;
        s2_err_d   = s1_vld_q && (s1_last_q != is_end);
        s2_sum_d   = s2_sum_q;
        s2_nonce_d = s2_nonce_q;
        if (s1_vld_q) begin
            s2_sum_d   = sum;
            s2_nonce_d = nonce_q;
            if (!s1_last_q) begin
                acc_d = sum;
            end
        end
    end

    // Clear is applied before a same-edge completion so that completion seeds the new best.
    always_comb begin
        score_valid_d = s2_done_q;
        new_best_d    = 1'b0;
        score_d       = score_q;
        score_nonce_d = score_nonce_q;
        best_valid_d  = best_valid_q;
        best_score_d  = best_score_q;
        best_nonce_d  = best_nonce_q;
        frame_error_d = frame_error_q;
        if (clear_best_i) begin
            best_valid_d  = 1'b0;
            best_score_d  = SCORE_MAX;
            best_nonce_d  = '0;
            frame_error_d = 1'b0;
        end
        if (s2_err_q) begin
            frame_error_d = 1'b1;
        end
        if (s2_done_q) begin
            score_d       = s2_sum_q;
            score_nonce_d = s2_nonce_q;
            if (beats_best(s2_sum_q, best_score_d, best_valid_d)) begin
                best_valid_d = 1'b1;
                best_score_d = s2_sum_q;
                best_nonce_d = s2_nonce_q;
                new_best_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_cnt_q    <= '0;
            s1_vld_q      <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_first_q    <= 1'b0;
            s1_idx_q      <= '0;
            pc_q          <= '0;
            nonce_q       <= '0;
            acc_q         <= '0;
            s2_done_q     <= 1'b0;
            s2_err_q      <= 1'b0;
            s2_sum_q      <= '0;
            s2_nonce_q    <= '0;
            score_valid_q <= 1'b0;
            score_q       <= '0;
            score_nonce_q <= '0;
            new_best_q    <= 1'b0;
            best_valid_q  <= 1'b0;
            best_score_q  <= SCORE_MAX;
            best_nonce_q  <= '0;
            frame_error_q <= 1'b0;
        end else begin
            word_cnt_q    <= word_cnt_d;
            s1_vld_q      <= s1_vld_d;
            s1_last_q     <= s1_last_d;
            s1_first_q    <= s1_first_d;
            s1_idx_q      <= s1_idx_d;
            pc_q          <= pc_d;
            nonce_q       <= nonce_d;
            acc_q         <= acc_d;
            s2_done_q     <= s2_done_d;
            s2_err_q      <= s2_err_d;
            s2_sum_q      <= s2_sum_d;
            s2_nonce_q    <= s2_nonce_d;
            score_valid_q <= score_valid_d;
            score_q       <= score_d;
            score_nonce_q <= score_nonce_d;
            new_best_q    <= new_best_d;
            best_valid_q  <= best_valid_d;
            best_score_q  <= best_score_d;
            best_nonce_q  <= best_nonce_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign score_valid_o = score_valid_q;
    assign score_o       = score_q;
    assign score_nonce_o = score_nonce_q;
    assign new_best_o    = new_best_q;
    assign best_valid_o  = best_valid_q;
    assign best_score_o  = best_score_q;
    assign best_nonce_o  = best_nonce_q;
    assign frame_error_o = frame_error_q;

endmodule

// File: tb/tb_hash_score_tracker.sv
// Directed bench for hash_score_tracker: score pulses are logged by a monitor and
// compared against hand-computed Hamming distances, nonces and latencies.
module tb_hash_score_tracker;
    import skein_pkg::*;

    logic               clk_i;
    logic               rst_ni;
    logic               word_valid_i;
    logic [63:0]        word_i;
    logic               word_last_i;
    logic [63:0]        nonce_i;
    logic               clear_best_i;
    logic               score_valid_o;
    logic [SCORE_W-1:0] score_o;
    logic [63:0]        score_nonce_o;
    logic               new_best_o;
    logic               best_valid_o;
    logic [SCORE_W-1:0] best_score_o;
    logic [63:0]        best_nonce_o;
    logic               frame_error_o;

    hash_score_tracker #(.WORDS_PER_HASH(16), .NONCE_W(64)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .word_valid_i  (word_valid_i),
        .word_i        (word_i),
        .word_last_i   (word_last_i),
        .nonce_i       (nonce_i),
        .clear_best_i  (clear_best_i),
        .score_valid_o (score_valid_o),
        .score_o       (score_o),
        .score_nonce_o (score_nonce_o),
        .new_best_o    (new_best_o),
        .best_valid_o  (best_valid_o),
        .best_score_o  (best_score_o),
        .best_nonce_o  (best_nonce_o),
        .frame_error_o (frame_error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int                 cyc;
        logic [SCORE_W-1:0] score;
        logic [63:0]        nonce;
        logic               nb;
        logic [SCORE_W-1:0] best;
        logic [63:0]        bnonce;
    } pulse_t;

    pulse_t pq[$];
    int     cyc      = 0;
    int     last_cyc = 0;
    int     n_checks = 0;
    int     n_fail   = 0;

    // Edge index of each accepted last word, and of each score pulse seen after an edge.
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (rst_ni && word_valid_i && word_last_i) last_cyc <= cyc;
    end

    always @(negedge clk_i) begin
        pulse_t p;
        if (score_valid_o === 1'b1) begin
            p.cyc    = cyc - 1;
            p.score  = score_o;
            p.nonce  = score_nonce_o;
            p.nb     = new_best_o;
            p.best   = best_score_o;
            p.bnonce = best_nonce_o;
            pq.push_back(p);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [63:0] w, input logic last, input logic [63:0] nonce);
        @(negedge clk_i);
        word_valid_i = 1'b1;
        word_i       = w;
        word_last_i  = last;
        nonce_i      = nonce;
        @(posedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            word_valid_i = 1'b0;
            word_last_i  = 1'b0;
            @(posedge clk_i);
        end
    endtask

    task automatic send_cand(input logic [63:0] w, input int n, input int last_at,
                             input logic [63:0] nonce);
        for (int i = 1; i <= n; i++) send_word(w, i == last_at, nonce);
    endtask

    task automatic expect_one(input string tag, input int score, input logic [63:0] nonce,
                              input logic nb, input int best, input logic [63:0] bnonce);
        idle(5);
        chk({tag, "_pulses"}, 64'(pq.size()), 64'd1);
        if (pq.size() > 0) begin
            chk({tag, "_latency"}, 64'(pq[0].cyc - last_cyc), 64'd2);
            chk({tag, "_score"}, 64'(pq[0].score), 64'(score));
            chk({tag, "_nonce"}, pq[0].nonce, nonce);
            chk({tag, "_new_best"}, 64'(pq[0].nb), 64'(nb));
            chk({tag, "_best_score"}, 64'(pq[0].best), 64'(best));
            chk({tag, "_best_nonce"}, pq[0].bnonce, bnonce);
        end
        chk({tag, "_best_valid"}, 64'(best_valid_o), 64'd1);
        pq.delete();
    endtask

    task automatic clear_pulse();
        @(negedge clk_i);
        word_valid_i = 1'b0;
        clear_best_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        clear_best_i = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_score_valid"}, 64'(score_valid_o), 64'd0);
        chk({tag, "_new_best"}, 64'(new_best_o), 64'd0);
        chk({tag, "_best_valid"}, 64'(best_valid_o), 64'd0);
        chk({tag, "_frame_error"}, 64'(frame_error_o), 64'd0);
        chk({tag, "_score"}, 64'(score_o), 64'd0);
        chk({tag, "_score_nonce"}, score_nonce_o, 64'd0);
        chk({tag, "_best_nonce"}, best_nonce_o, 64'd0);
        chk({tag, "_best_score"}, 64'(best_score_o), 64'h7FF);
    endtask

    initial begin
        logic [63:0] w;
        int gap;
        rst_ni       = 1'b0;
        word_valid_i = 1'b0;
        word_i       = '0;
        word_last_i  = 1'b0;
        nonce_i      = '0;
        clear_best_i = 1'b0;

        repeat (3) @(negedge clk_i);
        chk_reset_outputs("reset");
        rst_ni = 1'b1;

        // All-zero words: distance 0, first record becomes best.
        send_cand(64'h0, 16, 16, 64'd5);
        expect_one("zero", 0, 64'd5, 1'b1, 0, 64'd5);

        clear_pulse();
        chk("clear_best_valid", 64'(best_valid_o), 64'd0);
        chk("clear_best_score", 64'(best_score_o), 64'h7FF);
        chk("clear_best_nonce", best_nonce_o, 64'd0);

        send_cand(64'hFFFF_FFFF_FFFF_FFFF, 16, 16, 64'd1);
        expect_one("cand_a", 1024, 64'd1, 1'b1, 1024, 64'd1);
        send_cand(64'h1, 16, 16, 64'd2);
        expect_one("cand_b", 16, 64'd2, 1'b1, 16, 64'd2);
        send_cand(64'h1, 16, 16, 64'd3);
        expect_one("cand_c_tie", 16, 64'd3, 1'b0, 16, 64'd2);

        // Word i carries popcount i; bubbles between words must not change the sum.
        for (int i = 1; i <= 16; i++) begin
            w = (64'd1 << i) - 64'd1;
            send_word(w, i == 16, 64'd7);
            if (i < 16) begin
                gap = $urandom_range(0, 3);
                idle(gap);
            end
        end
        expect_one("bubbles", 136, 64'd7, 1'b0, 16, 64'd2);

        send_cand(64'hFF, 10, 10, 64'd8);
        idle(5);
        chk("short_frame_pulses", 64'(pq.size()), 64'd0);
        chk("short_frame_error", 64'(frame_error_o), 64'd1);
        pq.delete();
        send_cand(64'h3, 16, 16, 64'd9);
        expect_one("after_error", 32, 64'd9, 1'b0, 16, 64'd2);
        chk("error_sticky", 64'(frame_error_o), 64'd1);

        send_cand(64'hF, 16, 16, 64'd10);
        send_cand(64'h7, 16, 16, 64'd11);
        idle(5);
        chk("b2b_pulses", 64'(pq.size()), 64'd2);
        if (pq.size() == 2) begin
            chk("b2b_spacing", 64'(pq[1].cyc - pq[0].cyc), 64'd16);
            chk("b2b_score0", 64'(pq[0].score), 64'd64);
            chk("b2b_score1", 64'(pq[1].score), 64'd48);
            chk("b2b_nonce1", pq[1].nonce, 64'd11);
        end
        pq.delete();

        // Best at 100, then a 500 completion coinciding with clear.
        clear_pulse();
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd20);
        send_word((64'd1 << 36) - 64'd1, 1'b0, 64'd20);
        send_cand(64'h0, 14, 14, 64'd20);
        expect_one("best100", 100, 64'd20, 1'b1, 100, 64'd20);
        send_cand(64'h1, 3, 3, 64'd99);
        idle(5);
        chk("pre_clear_error", 64'(frame_error_o), 64'd1);
        pq.delete();
        send_cand(64'hFFFF_FFFF_FFFF_FFFF, 7, 0, 64'd21);
        send_word((64'd1 << 52) - 64'd1, 1'b0, 64'd21);
        send_cand(64'h0, 8, 8, 64'd21);
        @(negedge clk_i);
        word_valid_i = 1'b0;
        word_last_i  = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        clear_best_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        clear_best_i = 1'b0;
        chk("clr_cmp_best_valid", 64'(best_valid_o), 64'd1);
        chk("clr_cmp_best_score", 64'(best_score_o), 64'd500);
        chk("clr_cmp_best_nonce", best_nonce_o, 64'd21);
        chk("clr_cmp_frame_error", 64'(frame_error_o), 64'd0);
        chk("clr_cmp_new_best", 64'(new_best_o), 64'd1);
        idle(3);
        chk("clr_cmp_pulses", 64'(pq.size()), 64'd1);
        if (pq.size() > 0) begin
            chk("clr_cmp_latency", 64'(pq[0].cyc - last_cyc), 64'd2);
            chk("clr_cmp_score", 64'(pq[0].score), 64'd500);
        end
        pq.delete();

        // Asynchronous reset halfway through a candidate.
        send_cand(64'hFFFF_FFFF_FFFF_FFFF, 8, 0, 64'd30);
        @(negedge clk_i);
        word_valid_i = 1'b0;
        rst_ni       = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(5);
        chk("mid_reset_pulses", 64'(pq.size()), 64'd0);
        pq.delete();
        send_cand(64'h1, 16, 16, 64'd31);
        expect_one("post_reset", 16, 64'd31, 1'b1, 16, 64'd31);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
